// File: rtl/noc_depacketizer_pkg.sv
// noc_depacketizer_pkg: shared NoC/AXI field layout, flit-type decode and depacketizer FSM types.
//   Package Noc_parameters
//     - flit / ID / AXI field widths and LSB positions of every head-flit field
//     - flit_type_e      : decoded flit type (head, body, tail, illegal)
//     - depkt_state_e    : depacketizer FSM states
//     - decode_flit()    : maps the raw flit type field onto flit_type_e
package Noc_parameters;

    localparam int Noc_ID_X_Width     = 2;
    localparam int Noc_ID_Y_Width     = 2;
    localparam int Noc_ID_Width       = Noc_ID_X_Width + Noc_ID_Y_Width;
    localparam int Noc_Data_Width     = 32;
    localparam int Noc_Head_Bit       = 2;
    localparam int Noc_Flit_Width     = Noc_Head_Bit + Noc_Data_Width;
    localparam int Noc_Point_H        = Noc_Flit_Width - 1;

    localparam int Axi_TYPE_Bit       = 2;
    localparam int Axi_PACK_ORDER_Bit = 4;
    localparam int Axi_LEN_Bit        = 4;

    // Head flit layout, each value is the LSB of its field.
    localparam int Noc_Source_Point     = 0;
    localparam int Noc_Dest_Point       = Noc_Source_Point + Noc_ID_Width;
    localparam int Axi_Type_Point       = Noc_Dest_Point + Noc_ID_Width;
    localparam int Axi_Pack_Order_Point = Axi_Type_Point + Axi_TYPE_Bit;
    localparam int Axi_Len_Point        = Axi_Pack_Order_Point + Axi_PACK_ORDER_Bit;

    // Raw encodings of the flit type field.
    localparam logic [Noc_Head_Bit-1:0] Noc_Head_E = 2'b00;
    localparam logic [Noc_Head_Bit-1:0] Noc_Tail_H = 2'b01;
    localparam logic [Noc_Head_Bit-1:0] Noc_Head_H = 2'b10;
    localparam logic [Noc_Head_Bit-1:0] Noc_Ill_H  = 2'b11;

    typedef enum logic [Noc_Head_Bit-1:0] {
        FLIT_BODY    = Noc_Head_E,
        FLIT_TAIL    = Noc_Tail_H,
        FLIT_HEAD    = Noc_Head_H,
        FLIT_ILLEGAL = Noc_Ill_H
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE,
        HDR_OUT,
        DATA,
        DROP
    } depkt_state_e;

    function automatic flit_type_e decode_flit(input logic [Noc_Head_Bit-1:0] t);
        return t == Noc_Head_H ? FLIT_HEAD :
               t == Noc_Tail_H ? FLIT_TAIL :
               t == Noc_Head_E ? FLIT_BODY : FLIT_ILLEGAL;
    endfunction

endpackage

// File: rtl/noc_out_reg.sv
// noc_out_reg: one-entry valid/ready output register for the payload path.
//   clk, rst            : clock, asynchronous active-high reset
//   in_data, in_last    : beat to load
//   in_valid, in_ready  : load handshake (ready when empty or draining this cycle)
//   out_data, out_last  : registered beat, held stable while stalled
//   out_valid, out_ready: output handshake
module noc_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/noc_depacketizer.sv
// noc_depacketizer: turns NoC flits from a router local port into a header plus a payload burst.
//   clk, rst                         : clock, asynchronous active-high reset
//   flit_i, flit_valid_i, flit_ready_o: incoming flit stream
//   hdr_src_o/type_o/order_o/len_o    : registered header of the current packet
//   hdr_valid_o, hdr_ready_i          : header handshake
//   data_o, data_last_o               : payload beat from a single output register
//   data_valid_o, data_ready_i        : payload handshake
//   err_o                             : one-cycle pulse on any protocol error
module noc_depacketizer
    import Noc_parameters::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] LOCAL_X = '0,
    parameter logic [Noc_ID_Y_Width-1:0] LOCAL_Y = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Noc_Flit_Width-1:0]     flit_i,
    input  logic                          flit_valid_i,
    output logic                          flit_ready_o,
    output logic [Noc_ID_Width-1:0]       hdr_src_o,
    output logic [Axi_TYPE_Bit-1:0]       hdr_type_o,
    output logic [Axi_PACK_ORDER_Bit-1:0] hdr_order_o,
    output logic [Axi_LEN_Bit-1:0]        hdr_len_o,
    output logic                          hdr_valid_o,
    input  logic                          hdr_ready_i,
    output logic [Noc_Data_Width-1:0]     data_o,
    output logic                          data_valid_o,
    output logic                          data_last_o,
    input  logic                          data_ready_i,
    output logic                          err_o
);

    depkt_state_e              state;
    flit_type_e                ft;
    logic [Axi_LEN_Bit:0]      cnt;
    logic                      fire;
    logic                      dest_ok;
    logic                      at_end;
    logic                      hdr_load;
    logic                      push_valid;
    logic                      push_ready;
    logic                      push_last;
    logic [Noc_Data_Width-1:0] push_data;

    assign ft      = decode_flit(flit_i[Noc_Point_H -: Noc_Head_Bit]);
    assign dest_ok = flit_i[Noc_Dest_Point +: Noc_ID_Width] == {LOCAL_Y, LOCAL_X};
    assign at_end  = cnt == {1'b0, hdr_len_o};
    assign fire    = flit_valid_i && flit_ready_o;

    always_comb begin
        flit_ready_o = state == HDR_OUT ? 1'b0 : state == DATA ? push_ready : 1'b1;
        hdr_valid_o  = state == HDR_OUT;
        hdr_load     = fire && ft == FLIT_HEAD && dest_ok && (state == IDLE || state == DATA);
        // A head arriving mid-burst closes the burst with an empty last beat.
        push_valid   = state == DATA && fire && ft != FLIT_ILLEGAL;
        push_data    = ft == FLIT_HEAD ? '0 : flit_i[Noc_Data_Width-1:0];
        push_last    = ft == FLIT_HEAD || ft == FLIT_TAIL || at_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_src_o   <= '0;
            hdr_type_o  <= '0;
            hdr_order_o <= '0;
            hdr_len_o   <= '0;
        end else if (hdr_load) begin
            hdr_src_o   <= flit_i[Noc_Source_Point +: Noc_ID_Width];
            hdr_type_o  <= flit_i[Axi_Type_Point +: Axi_TYPE_Bit];
            hdr_order_o <= flit_i[Axi_Pack_Order_Point +: Axi_PACK_ORDER_Bit];
            hdr_len_o   <= flit_i[Axi_Len_Point +: Axi_LEN_Bit];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        if (ft == FLIT_HEAD) begin
                            state <= dest_ok ? HDR_OUT : DROP;
                            err_o <= !dest_ok;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                HDR_OUT: begin
                    if (hdr_ready_i) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (fire) begin
                        case (ft)
                            FLIT_HEAD: begin
                                err_o <= 1'b1;
                                state <= dest_ok ? HDR_OUT : DROP;
                            end
                            FLIT_TAIL: begin
                                err_o <= !at_end;
                                state <= IDLE;
                            end
                            FLIT_BODY: begin
                                // Counter stops at len: a body there means the tail went missing.
                                if (at_end) begin
                                    err_o <= 1'b1;
                                    state <= DROP;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                            default: err_o <= 1'b1;
                        endcase
                    end
                end
                DROP: begin
                    if (fire && ft == FLIT_TAIL) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    noc_out_reg #(.W(Noc_Data_Width)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_data   (push_data),
        .in_last   (push_last),
        .in_valid  (push_valid),
        .in_ready  (push_ready),
        .out_data  (data_o),
        .out_last  (data_last_o),
        .out_valid (data_valid_o),
        .out_ready (data_ready_i)
    );

endmodule
